kf76489_mixer_scheduler: RTL and testbench
==========================================

KF76489_MIXER_SCHEDULER -- requirements
Module: kf76489_mixer_scheduler

Interface
REQ-001 SHALL have parameter: ACC_WIDTH, default 8, mix accumulator/output width; legal values >= 8.
REQ-002 SHALL have port: clock  in  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port: sample_req  in  1  one-cycle strobe requesting one mixed sample.
REQ-005 SHALL have port: attenuation  in  16  per-channel 4-bit attenuation codes, channel n in bits [4n+3:4n], n = 0..3.
REQ-006 SHALL have port: digital_in  in  4  per-channel digital level, channel n in bit n.
REQ-007 SHALL have port: mute  in  4  per-channel mute mask; present only when KF76489_MIXER_MUTE_EN is defined.
REQ-008 SHALL have port: busy  out  1  high while a sample is being sequenced.
REQ-009 SHALL have port: mix_out  out  ACC_WIDTH  sum of four channel amplitudes, zero-extended.
REQ-010 SHALL have port: mix_valid  out  1  one-cycle strobe: mix_out updated this cycle.
REQ-011 SHALL have port: overrun  out  1  one-cycle strobe: sample_req dropped.

Function
REQ-012 SHALL time-share one attenuation table instance (4-bit code + digital level -> 6-bit amplitude) across channels 0..3, one channel per cycle.
REQ-013 Table amplitude SHALL be 0 when the digital level is 0; otherwise code 0000->63, 1000->50, 0100->40, 1100->32, 0010->25, 1010->20, 0110->16, 1110->13, 0001->10, 1001->8, 0101->6, 1101->5, 0011->4, 1011->3, 0111->2, 1111->0.
REQ-014 FSM SHALL have states IDLE, SCAN, DONE; reset state IDLE.
REQ-015 IDLE with sample_req=1: snapshot attenuation and digital_in (and mute when compiled in), clear accumulator, set channel index 0, go to SCAN.
REQ-016 SCAN: accumulator += amplitude of snapshotted channel[index]; index increments; after channel 3 is accumulated, go to DONE.
REQ-017 DONE: mix_out <= accumulator, mix_valid=1 for this cycle only, then IDLE.
REQ-018 Latency: request sampled in cycle N -> SCAN cycles N+1..N+4, mix_valid high in cycle N+5; busy high in cycles N+1..N+5.
REQ-019 sample_req in SCAN or DONE SHALL be ignored and SHALL assert overrun in the following cycle; snapshot and accumulation are unaffected.
REQ-020 Input changes after the snapshot SHALL NOT affect the current sample.
REQ-021 Accumulator SHALL be ACC_WIDTH bits and cannot overflow (max 4*63=252).
REQ-022 mix_out SHALL hold its value between mix_valid strobes.
REQ-023 Maximum throughput SHALL be one sample per 6 cycles; a request in cycle N+6 is accepted.

Reset
REQ-024 reset SHALL force state IDLE, index 0, accumulator 0, snapshot 0, mix_out 0, mix_valid 0, busy 0, overrun 0 at the next rising edge.
REQ-025 reset mid-SCAN or in DONE SHALL abort the sample without asserting mix_valid; reset has priority over sample_req in the same cycle.

Configuration
REQ-026 With KF76489_MIXER_MUTE_EN defined, mute[n]=1 in the snapshot SHALL force channel n's contribution to 0; timing is unchanged.
REQ-027 Without KF76489_MIXER_MUTE_EN, the mute port SHALL NOT exist and all channels SHALL always contribute.

Verification
REQ-028 All codes 0000, digital_in=1111, request -> mix_valid in cycle N+5, mix_out=252, busy high N+1..N+5.
REQ-029 Codes ch0..3 = 1000,0100,1111,0001, digital_in=1111 -> mix_out=50+40+0+10=100; repeat with digital_in=0101 -> 50+0=50.
REQ-030 Request at N, second request at N+2, then at N+5 -> overrun high in N+3 and N+6, one mix_valid only; request at N+6 accepted.
REQ-031 Change attenuation to 1111 in cycle N+2 after a request with all codes 0000, digital_in=1111 -> mix_out=252.
REQ-032 reset asserted in cycle N+3 -> no mix_valid, all outputs 0 from N+4; next request produces a correct sum.
REQ-033 With KF76489_MIXER_MUTE_EN: all codes 0000, digital_in=1111, mute=0011 -> mix_out=126, latency unchanged.

Source files
------------

// File: rtl/kf76489_mixer_scheduler.sv
// Four-channel PSG mixer: one shared attenuation table scanned one channel per cycle.
// Optional per-channel mute mask is compiled in with `define KF76489_MIXER_MUTE_EN.
//
// state | meaning
// IDLE  | waiting for sample_req_i; snapshot taken on acceptance
// SCAN  | adding amplitude of snapshotted channel idx_q (0..3)
// DONE  | mix_out_o carries the new sum, mix_valid_o high
module kf76489_mixer_scheduler #(
    parameter int ACC_WIDTH = 8
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 sample_req_i,
    input  logic [15:0]          attenuation_i,
    input  logic [3:0]           digital_in_i,
`ifdef KF76489_MIXER_MUTE_EN
    input  logic [3:0]           mute_i,
`endif
    output logic                 busy_o,
    output logic [ACC_WIDTH-1:0] mix_out_o,
    output logic                 mix_valid_o,
    output logic                 overrun_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           idx_q;
    logic [15:0]          att_q;
    logic [3:0]           dig_q;
    logic [3:0]           mute_q;
    logic [3:0]           mute_snap;
    logic [ACC_WIDTH-1:0] acc_q;
    logic [ACC_WIDTH-1:0] mix_q;
    logic                 overrun_q;
    logic                 accept;
    logic [3:0]           code;
    logic                 level;
    logic [5:0]           amp;
    logic [ACC_WIDTH-1:0] sum;

`ifdef KF76489_MIXER_MUTE_EN
    assign mute_snap = mute_i;
`else
    assign mute_snap = 4'b0000;
`endif

    assign accept = (state_q == IDLE) && sample_req_i;

    // Shared attenuation table: the single instance is steered by idx_q.
    always_comb begin
        code  = att_q[{idx_q, 2'b00} +: 4];
        level = dig_q[idx_q] & ~mute_q[idx_q];
        amp   = 6'd0;
        if (level) begin
            case (code)
                4'b0000: amp = 6'd63;
                4'b1000: amp = 6'd50;
                4'b0100: amp = 6'd40;
                4'b1100: amp = 6'd32;
                4'b0010: amp = 6'd25;
                4'b1010: amp = 6'd20;
                4'b0110: amp = 6'd16;
                4'b1110: amp = 6'd13;
                4'b0001: amp = 6'd10;
                4'b1001: amp = 6'd8;
                4'b0101: amp = 6'd6;
                4'b1101: amp = 6'd5;
                4'b0011: amp = 6'd4;
                4'b1011: amp = 6'd3;
                4'b0111: amp = 6'd2;
                default: amp = 6'd0;
            endcase
        end
        sum = acc_q + {{(ACC_WIDTH-6){1'b0}}, amp};
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sample_req_i) state_d = SCAN;
            SCAN:    if (idx_q == 2'd3) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o      = (state_q != IDLE);
        mix_valid_o = (state_q == DONE);
    end

    // mix_q is loaded on the last SCAN edge so it is already current while DONE strobes.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            idx_q     <= 2'd0;
            att_q     <= 16'd0;
            dig_q     <= 4'd0;
            mute_q    <= 4'd0;
            acc_q     <= '0;
            mix_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= sample_req_i && (state_q != IDLE);
            if (accept) begin
                att_q  <= attenuation_i;
                dig_q  <= digital_in_i;
                mute_q <= mute_snap;
                acc_q  <= '0;
                idx_q  <= 2'd0;
            end else if (state_q == SCAN) begin
                acc_q <= sum;
                idx_q <= idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    mix_q <= sum;
                end
            end
        end
    end

    assign mix_out_o = mix_q;
    assign overrun_o = overrun_q;

endmodule

// File: tb/tb_kf76489_mixer_scheduler.sv
// Directed bench for kf76489_mixer_scheduler; mute cases are built when
// KF76489_MIXER_MUTE_EN is defined.
module tb_kf76489_mixer_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sample_req = 1'b0;
    logic [15:0] attenuation = 16'd0;
    logic [3:0]  digital_in = 4'd0;
    logic [3:0]  mute = 4'd0;
    logic        busy;
    logic [7:0]  mix_out;
    logic        mix_valid;
    logic        overrun;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    kf76489_mixer_scheduler #(.ACC_WIDTH(8)) dut (
        .clock_i       (clk),
        .reset_i       (reset),
        .sample_req_i  (sample_req),
        .attenuation_i (attenuation),
        .digital_in_i  (digital_in),
`ifdef KF76489_MIXER_MUTE_EN
        .mute_i        (mute),
`endif
        .busy_o        (busy),
        .mix_out_o     (mix_out),
        .mix_valid_o   (mix_valid),
        .overrun_o     (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Request in cycle N, scrambles inputs after the snapshot, checks N..N+6.
    task automatic run_sample(input string tag, input logic [15:0] att, input logic [3:0] dig,
                              input logic [3:0] mt, input logic [7:0] exp_mix);
        attenuation = att;
        digital_in  = dig;
        mute        = mt;
        sample_req  = 1'b1;
        chk({tag, "_busy_n"}, busy, 0);
        tick();
        sample_req  = 1'b0;
        attenuation = ~att;
        digital_in  = ~dig;
        mute        = ~mt;
        for (int k = 1; k <= 5; k++) begin
            chk({tag, "_busy"}, busy, 1);
            chk({tag, "_valid"}, mix_valid, (k == 5));
            if (k == 5) chk({tag, "_mix"}, mix_out, exp_mix);
            tick();
        end
        chk({tag, "_busy_end"}, busy, 0);
        chk({tag, "_valid_end"}, mix_valid, 0);
        chk({tag, "_hold"}, mix_out, exp_mix);
        mute = 4'd0;
    endtask

    initial begin
        // Reset, with a simultaneous request that must lose to reset
        sample_req = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        sample_req = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_mix", mix_out, 0);
        chk("rst_valid", mix_valid, 0);
        chk("rst_overrun", overrun, 0);
        tick();
        chk("rst_busy2", busy, 0);

        run_sample("full", 16'h0000, 4'hF, 4'h0, 8'd252);
        run_sample("mixA", 16'h1F48, 4'hF, 4'h0, 8'd100);
        run_sample("mixB", 16'h1F48, 4'h5, 4'h0, 8'd50);
        run_sample("tab1", 16'h6A2C, 4'hF, 4'h0, 8'd93);
        run_sample("tab2", 16'hD59E, 4'hF, 4'h0, 8'd32);
        run_sample("tab3", 16'h17B3, 4'hF, 4'h0, 8'd19);
        run_sample("dig0", 16'h0000, 4'h0, 4'h0, 8'd0);
        run_sample("dig8", 16'h0000, 4'h8, 4'h0, 8'd63);

        // Overrun: requests at c=0,2,5,6; only c=0 and c=6 are accepted
        for (int c = 0; c < 13; c++) begin
            sample_req  = (c == 0 || c == 2 || c == 5 || c == 6);
            digital_in  = 4'hF;
            attenuation = (c == 0) ? 16'h0000 : (c == 6) ? 16'h1F48 : 16'hFFFF;
            chk("ovr_overrun", overrun, (c == 3 || c == 6));
            chk("ovr_valid", mix_valid, (c == 5 || c == 11));
            chk("ovr_busy", busy, ((c >= 1 && c <= 5) || (c >= 7 && c <= 11)));
            if (c == 5) chk("ovr_mix1", mix_out, 252);
            if (c == 11) chk("ovr_mix2", mix_out, 100);
            tick();
        end
        sample_req = 1'b0;

        // Inputs change mid-scan
        for (int c = 0; c < 7; c++) begin
            sample_req  = (c == 0);
            attenuation = (c < 2) ? 16'h0000 : 16'hFFFF;
            digital_in  = 4'hF;
            if (c == 5) chk("late_mix", mix_out, 252);
            if (c == 5) chk("late_valid", mix_valid, 1);
            tick();
        end

        // Reset during SCAN aborts the sample
        for (int c = 0; c < 8; c++) begin
            sample_req  = (c == 0);
            attenuation = 16'h1F48;
            digital_in  = 4'hF;
            reset       = (c == 3);
            if (c >= 4) begin
                chk("abort_valid", mix_valid, 0);
                chk("abort_busy", busy, 0);
                chk("abort_overrun", overrun, 0);
                chk("abort_mix", mix_out, 0);
            end
            tick();
        end
        reset = 1'b0;
        run_sample("after_abort", 16'h1F48, 4'hF, 4'h0, 8'd100);

`ifdef KF76489_MIXER_MUTE_EN
        run_sample("mute3", 16'h0000, 4'hF, 4'h3, 8'd126);
        run_sample("muteA", 16'h1F48, 4'hF, 4'h1, 8'd50);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
